// File: rtl/mul_pkg.sv
// Shared constants and state type for the sequential shift-add multiplier.
package mul_pkg;

  localparam int unsigned MUL_WIDTH = 32;
  localparam int unsigned MUL_CNT_W = $clog2(MUL_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_t;

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration: conditionally add the multiplicand into the high half,
// then shift {carry, accumulator, multiplier} right by one.
module mul_step
  import mul_pkg::*;
#(
  parameter int unsigned W = MUL_WIDTH
) (
  input  logic [W-1:0]   acc_i,
  input  logic [W-1:0]   mplr_i,
  input  logic [W-1:0]   mcand_i,
  output logic [2*W-1:0] next_o
);

  logic [W:0] sum;

  // Carry-out of the W+1-bit add becomes the new MSB after the shift.
  assign sum    = {1'b0, acc_i} + (mplr_i[0] ? {1'b0, mcand_i} : '0);
  assign next_o = {sum, mplr_i[W-1:1]};

endmodule

// File: rtl/mul_seq.sv
// Sequential WIDTHxWIDTH multiplier, one multiplier bit per cycle; MulAns only ever
// carries completed products. Optional signed mode enabled by defining MUL_SIGNED_EN.
module mul_seq
  import mul_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Start,
  input  logic [MUL_WIDTH-1:0]   SrcA,
  input  logic [MUL_WIDTH-1:0]   SrcB,
`ifdef MUL_SIGNED_EN
  input  logic                   Signed,
`endif
  output logic                   Busy,
  output logic                   Done,
  output logic [2*MUL_WIDTH-1:0] MulAns
);

  localparam int unsigned WIDTH = MUL_WIDTH;

  mul_state_t           state_q;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   ans_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [MUL_CNT_W-1:0] cnt_q;

  logic [2*WIDTH-1:0]   step_d;
  logic [2*WIDTH-1:0]   prod_c;
  logic [WIDTH-1:0]     mcand_c;
  logic [WIDTH-1:0]     mplr_c;

`ifdef MUL_SIGNED_EN
  logic neg_q;
  logic neg_c;

  // Magnitudes at capture; 0x80..0 maps onto itself, i.e. the unsigned value 2^(W-1).
  assign mcand_c = (Signed && SrcA[WIDTH-1]) ? WIDTH'(-SrcA) : SrcA;
  assign mplr_c  = (Signed && SrcB[WIDTH-1]) ? WIDTH'(-SrcB) : SrcB;
  assign neg_c   = Signed && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
  assign prod_c  = neg_q ? (2*WIDTH)'(-step_d) : step_d;
`else
  assign mcand_c = SrcA;
  assign mplr_c  = SrcB;
  assign prod_c  = step_d;
`endif

  mul_step #(.W(WIDTH)) u_step (
    .acc_i   (acc_q[2*WIDTH-1:WIDTH]),
    .mplr_i  (acc_q[WIDTH-1:0]),
    .mcand_i (mcand_q),
    .next_o  (step_d)
  );

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ans_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
`ifdef MUL_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (Start) begin
            state_q <= BUSY;
            busy_q  <= 1'b1;
            acc_q   <= {{WIDTH{1'b0}}, mplr_c};
            mcand_q <= mcand_c;
            cnt_q   <= MUL_CNT_W'(WIDTH);
`ifdef MUL_SIGNED_EN
            neg_q   <= neg_c;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          acc_q <= step_d;
          cnt_q <= cnt_q - MUL_CNT_W'(1);
          // Final step: publish the product together with the Done pulse.
          if (cnt_q == MUL_CNT_W'(1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            ans_q   <= prod_c;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign MulAns = ans_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed self-checking bench for mul_seq; signed cases run when MUL_SIGNED_EN is defined.
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
`ifdef MUL_SIGNED_EN
  logic        Signed;
`endif
  logic        Busy;
  logic        Done;
  logic [63:0] MulAns;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_seq dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (Start),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
`ifdef MUL_SIGNED_EN
    .Signed (Signed),
`endif
    .Busy   (Busy),
    .Done   (Done),
    .MulAns (MulAns)
  );

  // Issues one operation from a negedge and waits (bounded) for Done; lat counts negedges after accept.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] prod, output int lat);
    Start = 1'b1; SrcA = a; SrcB = b;
    @(negedge clk);
    Start = 1'b0;
    lat = 1;
    while (Done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    prod = MulAns;
  endtask

  task automatic test_reset();
    reset = 1'b1; Start = 1'b0; SrcA = '0; SrcB = '0;
    repeat (2) @(negedge clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
    checks++; if (MulAns !== 64'h0) begin errors++; $display("FAIL reset_ans got %h want 0", MulAns); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic exp_busy, exp_done;
    logic [63:0] exp_ans;
    @(negedge clk);
    Start = 1'b1; SrcA = 32'd3; SrcB = 32'd5;
    @(negedge clk);
    Start = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      exp_busy = (k <= 32);
      exp_done = (k == 33);
      exp_ans  = (k == 33) ? 64'hF : 64'h0;
      checks++; if (Busy !== exp_busy) begin errors++; $display("FAIL basic_busy k=%0d got %b want %b", k, Busy, exp_busy); end
      checks++; if (Done !== exp_done) begin errors++; $display("FAIL basic_done k=%0d got %b want %b", k, Done, exp_done); end
      checks++; if (MulAns !== exp_ans) begin errors++; $display("FAIL basic_ans k=%0d got %h want %h", k, MulAns, exp_ans); end
      if (k < 33) @(negedge clk);
    end
    @(negedge clk);
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got %b want 0", Done); end
    checks++; if (MulAns !== 64'hF) begin errors++; $display("FAIL basic_hold got %h want f", MulAns); end
  endtask

  task automatic test_unsigned_max();
    logic [63:0] p;
    int lat;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, p, lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL max_latency got %0d want 33", lat); end
    checks++; if (p !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL max_product got %h want fffffffe00000001", p); end
  endtask

  task automatic test_zero();
    logic [63:0] p;
    int lat;
    @(negedge clk);
    run_op(32'h0, 32'h1234, p, lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL zero_done got latency %0d want 33", lat); end
    checks++; if (p !== 64'h0) begin errors++; $display("FAIL zero_product got %h want 0", p); end
  endtask

  task automatic test_start_ignored();
    int lat;
    int extra = 0;
    @(negedge clk);
    Start = 1'b1; SrcA = 32'd7; SrcB = 32'd6;
    @(negedge clk);
    Start = 1'b0;
    for (lat = 1; lat < 40 && Done !== 1'b1; lat++) begin
      Start = (lat == 9);
      if (lat == 9) begin SrcA = 32'd100; SrcB = 32'd100; end
      @(negedge clk);
    end
    Start = 1'b0;
    checks++; if (lat !== 33) begin errors++; $display("FAIL ignored_latency got %0d want 33", lat); end
    checks++; if (MulAns !== 64'h2A) begin errors++; $display("FAIL ignored_product got %h want 2a", MulAns); end
    repeat (40) begin
      @(negedge clk);
      if (Done === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ignored_extra_done got %0d want 0", extra); end
    checks++; if (MulAns !== 64'h2A) begin errors++; $display("FAIL ignored_hold got %h want 2a", MulAns); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    Start = 1'b1; SrcA = 32'd16; SrcB = 32'd16;
    @(negedge clk);
    SrcA = 32'd2; SrcB = 32'd9;
    lat1 = 1;
    while (Done !== 1'b1 && lat1 < 40) begin @(negedge clk); lat1++; end
    checks++; if (lat1 !== 33) begin errors++; $display("FAIL b2b_first_latency got %0d want 33", lat1); end
    checks++; if (MulAns !== 64'h100) begin errors++; $display("FAIL b2b_first_product got %h want 100", MulAns); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_with_done got %b want 0", Busy); end
    @(negedge clk);
    Start = 1'b0;
    lat2 = 1;
    while (Done !== 1'b1 && lat2 < 40) begin @(negedge clk); lat2++; end
    checks++; if (lat2 !== 33) begin errors++; $display("FAIL b2b_gap got %0d want 33", lat2); end
    checks++; if (MulAns !== 64'h12) begin errors++; $display("FAIL b2b_second_product got %h want 12", MulAns); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] p;
    int lat;
    int extra = 0;
    @(negedge clk);
    Start = 1'b1; SrcA = 32'd7; SrcB = 32'd6;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", Busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL mid_done got %b want 0", Done); end
    checks++; if (MulAns !== 64'h0) begin errors++; $display("FAIL mid_ans got %h want 0", MulAns); end
    repeat (40) begin
      @(negedge clk);
      if (Done === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL mid_discard got %0d done pulses want 0", extra); end
    run_op(32'd4, 32'd4, p, lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mid_after_latency got %0d want 33", lat); end
    checks++; if (p !== 64'h10) begin errors++; $display("FAIL mid_after_product got %h want 10", p); end
  endtask

`ifdef MUL_SIGNED_EN
  task automatic test_signed();
    logic [63:0] p;
    int lat;
    Signed = 1'b1;
    @(negedge clk);
    run_op(32'hFFFF_FFFF, 32'h1, p, lat);
    checks++; if (p !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL signed_m1x1 got %h want ffffffffffffffff", p); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL signed_latency got %0d want 33", lat); end
    @(negedge clk);
    run_op(32'h8000_0000, 32'h8000_0000, p, lat);
    checks++; if (p !== 64'h4000_0000_0000_0000) begin errors++; $display("FAIL signed_minneg got %h want 4000000000000000", p); end
    @(negedge clk);
    run_op(32'hFFFF_FFFD, 32'hFFFF_FFF9, p, lat);
    checks++; if (p !== 64'h15) begin errors++; $display("FAIL signed_m3xm7 got %h want 15", p); end
    Signed = 1'b0;
    @(negedge clk);
    run_op(32'hFFFF_FFFF, 32'h1, p, lat);
    checks++; if (p !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL multu_m1x1 got %h want ffffffff", p); end
  endtask
`endif

  initial begin
`ifdef MUL_SIGNED_EN
    Signed = 1'b0;
`endif
    test_reset();
    test_basic();
    test_unsigned_max();
    test_zero();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
`ifdef MUL_SIGNED_EN
    test_signed();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
# mul_seq

Sequential 32x32 shift-add multiplier that produces the 64-bit product driven onto `MulAns` of the Hi/Lo register stage. It takes a single-cycle `Start` request with two operands, iterates one multiplier bit per cycle, and presents a stable result with a one-cycle `Done` pulse. `MulAns` carries only completed products, because the Hi/Lo stage loads on any non-zero `MulAns`.

## Interface
- `WIDTH`, 32, operand width; product is 2*WIDTH bits.
- `clk`  input  1  rising-edge clock for all state.
- `reset`  input  1  synchronous, active-high reset.
- `Start`  input  1  request; sampled only in IDLE or DONE.
- `SrcA`  input  WIDTH  multiplicand; captured on accepted `Start`.
- `SrcB`  input  WIDTH  multiplier; captured on accepted `Start`.
- `Signed`  input  1  (only with `MUL_SIGNED_EN`) 1 = signed `mult`, 0 = `multu`; captured with operands.
- `Busy`  output  1  high while iterating.
- `Done`  output  1  one-cycle pulse when `MulAns` updates.
- `MulAns`  output  2*WIDTH  last completed product.

## Operation
- Reset state: IDLE; `Busy`=0, `Done`=0, `MulAns`=0, internal accumulator, operand and counter registers=0.
- States: IDLE, BUSY, DONE.
  - IDLE: if `Start`, capture the operands, clear the accumulator, set the counter to WIDTH, go to BUSY.
  - BUSY: each cycle, if multiplier bit 0 = 1, add the multiplicand into the accumulator high half; then shift the {carry, accumulator} pair right by 1 and decrement the counter. Keep the carry-out in a WIDTH+1-bit add. When the counter reaches 1 on a step, go to DONE after that step.
  - DONE: load `MulAns` from the accumulator and pulse `Done`. If `Start` is high, accept a new operation and go to BUSY. Otherwise go to IDLE.
- `Start` while in BUSY is ignored. It is not queued.
- `MulAns` holds its value through later operations until the next DONE. Partial products never appear on `MulAns`.
- Arithmetic is unsigned modulo 2^(2*WIDTH). 0 x anything = 0, and the product is also 0 when written.
- Reset mid-operation: on the next edge, go to IDLE and clear all outputs. The in-flight result is discarded.

## Timing
- `Start` accepted at edge N:
  - `Busy`=1 during cycles N+1 to N+WIDTH.
  - DONE occupies cycle N+WIDTH+1.
  - `MulAns` and `Done` become valid after edge N+WIDTH+1. For WIDTH=32, that is 33 cycles from accept to result.
- `Done` is exactly one cycle wide.
- Back-to-back: `Start` held high during the DONE cycle begins the next operation with no idle cycle. Throughput is one product per WIDTH+1 cycles.
- `Busy` and `Done` are never high together.

## Configuration
- `MUL_SIGNED_EN` defined:
  - The `Signed` port exists.
  - When `Signed`=1, the operands are replaced by their magnitudes at capture, and the final product is negated (two's complement, 2*WIDTH bits) if exactly one operand sign bit was set.
  - The negation is applied when loading `MulAns` in DONE, so latency is unchanged.
  - The most-negative magnitude 0x80000000 is handled as the unsigned value 2^31.
- `MUL_SIGNED_EN` undefined:
  - No `Signed` port; all products are unsigned.
  - No sign registers or negation logic are synthesized.

## Structure
- Shared package `mul_pkg`:
  - `MUL_WIDTH` = 32.
  - State typedef `mul_state_t` {IDLE, BUSY, DONE}.
  - Counter width constant `MUL_CNT_W` = $clog2(MUL_WIDTH+1).
- One natural sub-module, `mul_step`: a combinational single-iteration add-and-shift. Inputs are accumulator, multiplier LSB and multiplicand; output is the next {accumulator, multiplier}. The FSM, counter and output registers stay in `mul_seq`.

## Test plan
- Reset, then 3 x 5 with `Start` at cycle 2 -> `Busy` for cycles 3–34, `Done` in cycle 35, `MulAns`=0x000000000000000F. `MulAns` stays 0 before that.
- 0xFFFFFFFF x 0xFFFFFFFF unsigned -> `MulAns`=0xFFFFFFFE00000001. Then 0 x 0x1234 -> `MulAns`=0 with the `Done` pulse.
- `Start` re-pulsed in cycle 10 of a busy operation (7 x 6) -> ignored; the single result 0x2A appears at the normal latency.
- `Start` held high through DONE with a second pair 2 x 9 -> second `Done` exactly 33 cycles after the first; `MulAns`=0x12.
- `reset` asserted mid-BUSY -> next cycle `Busy`=0, `Done`=0, `MulAns`=0. A subsequent 4 x 4 yields 0x10.
- With `MUL_SIGNED_EN`:
  - -1 x 1 signed -> 0xFFFFFFFFFFFFFFFF.
  - 0x80000000 x 0x80000000 signed -> 0x4000000000000000.
  - -3 x -7 signed -> 0x15.
